// File: rtl/vga_mode_sequencer.sv
// Round-robin sequencer sharing the VGA control PIO between NUM_REQ requesters.
// Optional build macro VGA_SEQ_SKIP_REDUNDANT_EN: grants that rewrite the current value skip the write and settle.
module vga_mode_sequencer #(
    parameter int NUM_REQ       = 2,
    parameter int DATA_W        = 2,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [1:0]                  pio_address,
    output logic                        pio_chipselect,
    output logic                        pio_write_n,
    output logic [DATA_W-1:0]           pio_writedata,
    output logic [DATA_W-1:0]           cur_value,
    output logic                        busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   cur_value_q, cur_value_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                cs_q, cs_d;
    logic                wr_n_q, wr_n_d;
    logic                busy_q, busy_d;

    logic                arb_found_s;
    logic [IW-1:0]       arb_idx_s;
    logic [DATA_W-1:0]   arb_data_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin search: first asserted request above the last grant, wrapping
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            arb_idx_s   = (!arb_found_s && req[(int'(rr_q) + i) % NUM_REQ])
                          ? IW'((int'(rr_q) + i) % NUM_REQ) : arb_idx_s;
            arb_found_s = arb_found_s | req[(int'(rr_q) + i) % NUM_REQ];
        end
        arb_data_s = req_data[int'(arb_idx_s)*DATA_W +: DATA_W];
    end

    // Next-state logic; outputs are decoded from the next state so they register cleanly
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        cur_value_d = cur_value_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found_s) begin
                    rr_d    = arb_idx_s;
                    grant_d = arb_idx_s;
                    data_d  = arb_data_s;
`ifdef VGA_SEQ_SKIP_REDUNDANT_EN
                    if (arb_data_s == cur_value_q) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WRITE;
                    end
`else
                    state_d = ST_WRITE;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                cur_value_d = data_q;
                cnt_d       = CW'(1);
                if (SETTLE_CYCLES == 0) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYCLES)) begin
                    state_d = ST_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cs_d   = (state_d == ST_WRITE);
        wr_n_d = (state_d != ST_WRITE);
        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_ACK) ? onehot(grant_d) : '0;
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_q        <= IW'(NUM_REQ - 1);
            grant_q     <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            cur_value_q <= '0;
            ack_q       <= '0;
            cs_q        <= 1'b0;
            wr_n_q      <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            cur_value_q <= cur_value_d;
            ack_q       <= ack_d;
            cs_q        <= cs_d;
            wr_n_q      <= wr_n_d;
            busy_q      <= busy_d;
        end
    end

    assign ack            = ack_q;
    assign pio_address    = 2'd0;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wr_n_q;
    assign pio_writedata  = data_q;
    assign cur_value      = cur_value_q;
    assign busy           = busy_q;

endmodule
